// File: rtl/flexible_logic_pipe.sv
// Two-stage valid/ready pipe computing Y = [~](A' op B') with optional operand
// inversion and a selectable AND/OR/XOR op; counts completed output transfers.
module flexible_logic_pipe #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic                   invert_a,
    input  logic                   invert_b,
    input  logic                   invert_y,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       y,
    output logic                   op_error,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;
    logic             s1_invert_a;
    logic             s1_invert_b;
    logic             s1_invert_y;

    logic             accept;
    logic             advance;
    logic             transfer;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] result;

    // Stage 1 can take new data whenever it is empty or is draining this cycle.
    assign advance  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !reset && (!s1_valid || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    always_comb begin
        opnd_a    = s1_invert_a ? ~s1_a : s1_a;
        opnd_b    = s1_invert_b ? ~s1_b : s1_b;
        op_result = opnd_a & opnd_b;
        case (s1_op)
            OP_AND:  op_result = opnd_a & opnd_b;
            OP_OR:   op_result = opnd_a | opnd_b;
            OP_XOR:  op_result = opnd_a ^ opnd_b;
            default: op_result = opnd_a & opnd_b;
        endcase
        result = s1_invert_y ? ~op_result : op_result;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_op       <= OP_AND;
            s1_invert_a <= 1'b0;
            s1_invert_b <= 1'b0;
            s1_invert_y <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid    <= 1'b1;
                s1_a        <= a;
                s1_b        <= b;
                s1_op       <= op;
                s1_invert_a <= invert_a;
                s1_invert_b <= invert_b;
                s1_invert_y <= invert_y;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            if (advance) begin
                out_valid <= 1'b1;
                y         <= result;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // op_error is sticky; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_error <= 1'b0;
        end else if (accept && (op == OP_RSV)) begin
            op_error <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (transfer) begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/flexible_logic_pipe.md
Name: flexible_logic_pipe

Overview:
- Parametrised, handshaked successor to the team's fixed 8-bit flexible AND gate.
- Computes Y = invY ? ~(A' op B') : (A' op B'), where A' = invA ? ~A : A and B' = invB ? ~B : B.
- op is selectable per transaction: AND, OR or XOR.
- Two-stage valid/ready pipeline with full throughput and backpressure; sits between simple streaming producers and consumers in the verification demo designs.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 1).
- COUNT_WIDTH, 16, width of the completed-transaction counter (>= 1).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a transaction.
- in_ready  output  1  block can accept a transaction this cycle.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 reserved.
- invert_a  input  1  invert A before the op.
- invert_b  input  1  invert B before the op.
- invert_y  input  1  invert the op result.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  WIDTH  registered result.
- op_error  output  1  sticky: a reserved op was accepted.
- count  output  COUNT_WIDTH  number of output transfers completed, modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (asynchronous, immediate on assertion; not gated by clock):
  - out_valid=0, y=0, op_error=0, count=0.
  - Stage-1 valid and all stage-1 data registers = 0.
  - in_ready=0 while reset is high.
- Stage 1 (input register):
  - Captures a, b, op, invert_a, invert_b and invert_y when in_valid && in_ready.
  - s1_valid is set on capture and cleared when stage 1 advances with no new capture.
- Stage 2 (output register):
  - Holds y and out_valid; y is computed combinationally from stage-1 contents.
  - Advance rule: stage 1 advances into stage 2 when s1_valid && (!out_valid || out_ready).
  - If out_valid && out_ready and stage 1 is empty, out_valid clears at the edge.
- in_ready = !reset && (!s1_valid || !out_valid || out_ready).
  - This is combinational from registers and out_ready; no combinational path from in_valid.
- Latency and throughput:
  - A transaction accepted at edge N is presented with out_valid=1 after edge N+1, with no backpressure.
  - One transaction per cycle is sustained while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, y and out_valid hold stable and unchanged.
  - Stage 1 can still absorb one more transaction, so up to 2 transactions are in flight.
  - in_ready drops to 0 only when both stages are full and out_ready=0.
- Ordering: results emerge in acceptance order; no drop or duplication under any handshake pattern.
- Simultaneous events: an output transfer and a stage-1 advance on the same edge replace y with the new result and keep out_valid=1.
- Reserved op 11:
  - Computed as AND.
  - op_error sets at the edge where stage 1 captures op=11.
  - op_error stays set until reset.
- count:
  - Increments by 1 on every edge where out_valid && out_ready.
  - Wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Inputs are sampled only on accepting edges; changes while in_ready=0 or in_valid=0 have no effect.
- Reset mid-operation: all in-flight transactions are discarded. After reset deasserts, the first accepted transaction behaves as from a cold start.
- Width rule: all logic is bitwise over WIDTH bits; there is no carry or cross-bit interaction.

Test Plan:
- WIDTH=8, op=AND, no inverts, a=0xF0, b=0xCC, one-cycle in_valid, out_ready=1 -> out_valid one edge after acceptance, y=0xC0, count=1.
- Invert cases:
  - op=OR, invert_a=1, a=0xF0, b=0xCC -> y=0xCF.
  - Same with invert_y=1 -> y=0x30.
  - op=XOR, invert_b=1, a=0xAA, b=0xFF -> y=0xAA.
- Backpressure:
  - Stream 4 transactions (a=0x01..0x04, b=0xFF, AND) with out_ready=0 for the first 3 cycles.
  - Expect in_ready=0 after 2 accepts, y=0x01 held stable.
  - After release: outputs 0x01,0x02,0x03,0x04 in order, count=4.
- Reserved op: op=11, a=0x3C, b=0x0F -> y=0x0C and op_error=1; op_error remains 1 after 10 further valid transactions; reset clears it.
- Counter wrap: COUNT_WIDTH=4, 17 back-to-back transfers with out_ready=1 -> count=1.
- Reset mid-operation:
  - Setup: 2 transactions in flight, out_ready=0.
  - Assert reset between edges -> out_valid=0, y=0, in_ready=0 immediately.
  - After deassertion -> in_ready=1, and no stale result is ever emitted.
